// File: rtl/fir_package.sv
// Shared types for the FIR MAC engine: controller/engine bundles,
// engine FSM states and field widths.
package fir_package;

    localparam int FIR_ENG_SHIFT_W = 5;
    localparam int FIR_LEN_W       = 16;

    typedef struct packed {
        logic                       clear;
        logic                       enable;
        logic                       start;
        logic                       simple_mul;
        logic [FIR_ENG_SHIFT_W-1:0] shift;
        logic [FIR_LEN_W-1:0]       len;
    } ctrl_engine_t;

    typedef struct packed {
        logic [FIR_LEN_W-1:0] cnt;
        logic                 acc_valid;
    } flags_engine_t;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_LOAD_C,
        ENG_RUN,
        ENG_OUT,
        ENG_DONE
    } engine_state_t;

endpackage

// File: rtl/hwpe_stream_if.sv
// Minimal hwpe_stream: data/valid/ready.
// slave = consumer side, master = producer side.
interface hwpe_stream_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport slave  (input data, input valid, output ready);
    modport master (output data, output valid, input ready);

endinterface

// File: rtl/fir_mac_pipe.sv
// Two-stage MAC datapath: stage 1 registers a*b, stage 2 either emits
// (p>>>shift) as a stream beat or accumulates p; also drives the OUT beat.
// Ports: clk_i/rst_ni, clear_i/enable_i, simple_i/shift_i (job config),
//   in_fire_i + a_i/b_i (join), seed_i + c_i (acc load), out_en_i,
//   d_ready_i; outputs s1_free_o, busy_o, d_valid_o, d_data_o.
module fir_mac_pipe
    import fir_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic                       simple_i,
    input  logic [FIR_ENG_SHIFT_W-1:0] shift_i,
    input  logic                       in_fire_i,
    input  logic [DATA_WIDTH-1:0]      a_i,
    input  logic [DATA_WIDTH-1:0]      b_i,
    input  logic                       seed_i,
    input  logic [DATA_WIDTH-1:0]      c_i,
    input  logic                       out_en_i,
    input  logic                       d_ready_i,
    output logic                       s1_free_o,
    output logic                       busy_o,
    output logic                       d_valid_o,
    output logic [DATA_WIDTH-1:0]      d_data_o
);

    logic                         s1_v;
    logic signed [2*DATA_WIDTH-1:0] p_q;
    logic                         d_v;
    logic [DATA_WIDTH-1:0]        d_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    logic signed [ACC_WIDTH-1:0]  p_ext;
    logic signed [ACC_WIDTH-1:0]  c_ext;
    logic [DATA_WIDTH-1:0]        p_lo;
    logic [DATA_WIDTH-1:0]        acc_lo;
    logic                         stall;
    logic                         s1_adv;

    assign p_ext  = ACC_WIDTH'(p_q);
    assign c_ext  = ACC_WIDTH'(signed'(c_i));
    assign p_lo   = DATA_WIDTH'(p_ext >>> shift_i);
    assign acc_lo = DATA_WIDTH'(acc_q >>> shift_i);

    // Only the streaming path can back-pressure stage 1.
    assign stall     = d_v & ~d_ready_i;
    assign s1_adv    = s1_v & ~(simple_i & stall);
    assign s1_free_o = ~s1_v | s1_adv;
    assign busy_o    = s1_v | d_v;

    assign d_valid_o = d_v | out_en_i;
    assign d_data_o  = out_en_i ? acc_lo : d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v  <= 1'b0;
            p_q   <= '0;
            d_v   <= 1'b0;
            d_q   <= '0;
            acc_q <= '0;
        end else if (clear_i) begin
            s1_v  <= 1'b0;
            p_q   <= '0;
            d_v   <= 1'b0;
            d_q   <= '0;
            acc_q <= '0;
        end else if (enable_i) begin
            if (in_fire_i) begin
                s1_v <= 1'b1;
                p_q  <= (2*DATA_WIDTH)'(signed'(a_i))
                      * (2*DATA_WIDTH)'(signed'(b_i));
            end else if (s1_adv) begin
                s1_v <= 1'b0;
            end

            if (s1_adv & simple_i) begin
                d_v <= 1'b1;
                d_q <= p_lo;
            end else if (d_v & d_ready_i) begin
                d_v <= 1'b0;
            end

            if (seed_i) begin
                acc_q <= c_ext;
            end else if (s1_adv & ~simple_i) begin
                acc_q <= acc_q + p_ext;
            end
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// FIR MAC engine top: job FSM, pair counter, a/b join and flags.
// Ports: clk_i, rst_ni, test_mode_i, a_i/b_i/c_i (stream slaves),
//   d_o (stream master), ctrl_i (ctrl_engine_t), flags_o (flags_engine_t).
module fir_mac_engine
    import fir_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int LEN_WIDTH  = FIR_LEN_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          test_mode_i,
    hwpe_stream_if.slave  a_i,
    hwpe_stream_if.slave  b_i,
    hwpe_stream_if.slave  c_i,
    hwpe_stream_if.master d_o,
    input  ctrl_engine_t  ctrl_i,
    output flags_engine_t flags_o
);

    engine_state_t              state_q, state_d;
    logic [LEN_WIDTH-1:0]       cnt_q;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [FIR_ENG_SHIFT_W-1:0] shift_q;
    logic                       simple_q;

    logic act;
    logic start_ok;
    logic join_rdy;
    logic c_rdy;
    logic seed;
    logic out_en;
    logic d_hs;
    logic s1_free;
    logic busy;
    logic unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign act      = ~ctrl_i.clear & ctrl_i.enable;
    assign start_ok = ctrl_i.start
                    & (state_q == ENG_IDLE | state_q == ENG_DONE);
    // a and b are only acknowledged together so pairs never split.
    assign join_rdy = act & (state_q == ENG_RUN)
                    & a_i.valid & b_i.valid
                    & (cnt_q < len_q) & s1_free;
    assign c_rdy    = act & (state_q == ENG_LOAD_C);
    assign seed     = c_rdy & c_i.valid;
    assign out_en   = (state_q == ENG_OUT);
    assign d_hs     = d_o.valid & d_o.ready;

    assign a_i.ready = join_rdy;
    assign b_i.ready = join_rdy;
    assign c_i.ready = c_rdy;

    assign flags_o.cnt       = FIR_LEN_W'(cnt_q);
    assign flags_o.acc_valid = (state_q == ENG_DONE);

    fir_mac_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_pipe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (ctrl_i.clear),
        .enable_i (ctrl_i.enable),
        .simple_i (simple_q),
        .shift_i  (shift_q),
        .in_fire_i(join_rdy),
        .a_i      (a_i.data),
        .b_i      (b_i.data),
        .seed_i   (seed),
        .c_i      (c_i.data),
        .out_en_i (out_en),
        .d_ready_i(d_o.ready),
        .s1_free_o(s1_free),
        .busy_o   (busy),
        .d_valid_o(d_o.valid),
        .d_data_o (d_o.data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_i.clear) begin
            state_d = ENG_IDLE;
        end else if (ctrl_i.enable) begin
            unique case (state_q)
                ENG_IDLE, ENG_DONE: begin
                    if (ctrl_i.start) begin
                        if (ctrl_i.len == '0)
                            state_d = ENG_DONE;
                        else if (ctrl_i.simple_mul)
                            state_d = ENG_RUN;
                        else
                            state_d = ENG_LOAD_C;
                    end
                end
                ENG_LOAD_C: if (c_i.valid) state_d = ENG_RUN;
                ENG_RUN: begin
                    if (cnt_q == len_q && !busy)
                        state_d = simple_q ? ENG_DONE : ENG_OUT;
                end
                ENG_OUT: if (d_hs) state_d = ENG_DONE;
                default: state_d = ENG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            simple_q <= 1'b0;
        end else if (ctrl_i.clear) begin
            cnt_q    <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            simple_q <= 1'b0;
        end else if (ctrl_i.enable) begin
            if (start_ok) begin
                cnt_q    <= '0;
                len_q    <= LEN_WIDTH'(ctrl_i.len);
                shift_q  <= ctrl_i.shift;
                simple_q <= ctrl_i.simple_mul;
            end else if (join_rdy) begin
                cnt_q <= cnt_q + LEN_WIDTH'(1);
            end
        end
    end

endmodule
